// File: rtl/comp_wr_buffer_if.sv
// Signal bundle between the DPCM compressor, the compressed-word write buffer
// and the SDRAM controller write port.
interface comp_wr_buffer_if #(
    parameter int ADDR_W = 23,
    parameter int LVL_W  = 10
);
    logic              i_valid;
    logic [15:0]       i_data;
    logic              o_burst_req;
    logic [ADDR_W-1:0] o_burst_addr;
    logic [8:0]        o_burst_len;
    logic              i_burst_ack;
    logic              i_rd;
    logic [15:0]       o_rd_data;
    logic [LVL_W-1:0]  o_level;
    logic              o_overflow;
    logic              o_frame_done;

    modport slave (
        input  i_valid, i_data, i_burst_ack, i_rd,
        output o_burst_req, o_burst_addr, o_burst_len, o_rd_data,
               o_level, o_overflow, o_frame_done
    );

    modport master (
        output i_valid, i_data, i_burst_ack, i_rd,
        input  o_burst_req, o_burst_addr, o_burst_len, o_rd_data,
               o_level, o_overflow, o_frame_done
    );
endinterface

// File: rtl/comp_wr_buffer.sv
// Buffers compressed pixel words in a FIFO and issues fixed-length SDRAM burst
// write requests with linear frame addresses; bursts never cross a frame end.
module comp_wr_buffer #(
    parameter int DEPTH     = 512,
    parameter int BURST     = 256,
    parameter int FRAME_PIX = 480000,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 23
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    comp_wr_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(FRAME_PIX + 1);
    localparam int CMP_W = (CNT_W > LVL_W) ? CNT_W : LVL_W;

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t            state_q, state_d;
    logic [15:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  in_cnt_q, offset_q;
    logic [CMP_W-1:0]  len_q, xfer_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              flush_q, overflow_q, frame_done_q;
    logic              burst_req;

    logic              push, pop, in_wrap, start, xfer_last, frame_wrap;
    logic [CMP_W-1:0]  level_w, remain_w, len_w, offset_end_w;

    // A full FIFO still accepts a word when a pop frees a slot in the same cycle
    assign pop     = bus.i_rd && (state_q == XFER) && (level_q != '0);
    assign push    = bus.i_valid && ((level_q != LVL_W'(DEPTH)) || pop);
    assign in_wrap = bus.i_valid && (in_cnt_q == CNT_W'(FRAME_PIX - 1));

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_comb begin
        level_w  = CMP_W'(level_q);
        remain_w = CMP_W'(FRAME_PIX) - CMP_W'(offset_q);
        len_w    = level_w;
        if (len_w > CMP_W'(BURST)) begin
            len_w = CMP_W'(BURST);
        end
        if (len_w > remain_w) begin
            len_w = remain_w;
        end
    end

    assign start        = (level_w >= CMP_W'(BURST)) || (flush_q && (level_q != '0));
    assign xfer_last    = pop && ((xfer_cnt_q + 1'b1) == len_q);
    assign offset_end_w = CMP_W'(offset_q) + len_q;
    assign frame_wrap   = (offset_end_w == CMP_W'(FRAME_PIX));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)           state_d = REQ;
            REQ:     if (bus.i_burst_ack) state_d = XFER;
            XFER:    if (xfer_last)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        burst_req = 1'b0;
        if (state_q == REQ) begin
            burst_req = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            in_cnt_q     <= '0;
            offset_q     <= '0;
            len_q        <= '0;
            xfer_cnt_q   <= '0;
            addr_q       <= '0;
            flush_q      <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            level_q      <= level_d;
            frame_done_q <= xfer_last && frame_wrap;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (bus.i_valid && !push) begin
                overflow_q <= 1'b1;
            end
            // Dropped words still count, so frame alignment survives an overflow
            if (bus.i_valid) begin
                in_cnt_q <= in_wrap ? '0 : in_cnt_q + 1'b1;
            end
            if (in_wrap) begin
                flush_q <= 1'b1;
            end else if (((state_q == IDLE) && (level_q == '0)) || (xfer_last && (level_d == '0))) begin
                flush_q <= 1'b0;
            end
            if ((state_q == IDLE) && start) begin
                addr_q     <= ADDR_W'(BASE_ADDR) + ADDR_W'(offset_q);
                len_q      <= len_w;
                xfer_cnt_q <= '0;
            end else if (pop) begin
                xfer_cnt_q <= xfer_cnt_q + 1'b1;
            end
            if (xfer_last) begin
                offset_q <= frame_wrap ? '0 : CNT_W'(offset_end_w);
            end
        end
    end

    assign bus.o_burst_req  = burst_req;
    assign bus.o_burst_addr = addr_q;
    assign bus.o_burst_len  = 9'(len_q);
    assign bus.o_rd_data    = (level_q == '0) ? 16'h0000 : mem_q[rd_ptr_q];
    assign bus.o_level      = level_q;
    assign bus.o_overflow   = overflow_q;
    assign bus.o_frame_done = frame_done_q;

endmodule

// File: tb/tb_comp_wr_buffer.sv
// Directed bench for comp_wr_buffer with a 1000-word frame so frame-end
// flush, wrap and frame_done are reached in a short run.
module tb_comp_wr_buffer;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    logic fd;

    comp_wr_buffer_if #(.ADDR_W(23), .LVL_W(10)) bus ();

    comp_wr_buffer #(
        .DEPTH(512), .BURST(256), .FRAME_PIX(1000), .BASE_ADDR(0), .ADDR_W(23)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        rd;
        logic        ack;
        logic [9:0]  lvl;
        logic [15:0] rdd;
        logic        req;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.i_valid = 1'b0;
        bus.i_data = 16'h0;
        bus.i_rd = 1'b0;
        bus.i_burst_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic push_n(input int n, input logic [15:0] d0);
        for (int i = 0; i < n; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = d0 + 16'(i);
            step();
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_req(input int bound, output logic seen);
        int w;
        w = 0;
        while (!bus.o_burst_req && w < bound) begin
            step();
            w++;
        end
        seen = bus.o_burst_req;
        if (!seen) chk("req_timeout", 32'(seen), 32'd1);
    endtask

    task automatic serve_burst(input logic [22:0] ea, input int el,
                               input logic [15:0] d0, output logic frame_done);
        logic seen;
        frame_done = 1'b0;
        wait_req(3000, seen);
        if (!seen) return;
        chk("burst_addr", 32'(bus.o_burst_addr), 32'(ea));
        chk("burst_len", 32'(bus.o_burst_len), 32'(el));
        bus.i_burst_ack = 1'b1;
        step();
        bus.i_burst_ack = 1'b0;
        chk("req_drop", 32'(bus.o_burst_req), 32'd0);
        for (int i = 0; i < el; i++) begin
            chk("pop_data", 32'(bus.o_rd_data), 32'(d0 + 16'(i)));
            bus.i_rd = 1'b1;
            step();
        end
        bus.i_rd = 1'b0;
        frame_done = bus.o_frame_done;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        n_pass = 0;
        n_total = 0;
        vecs[0] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 10'd1, 16'hA5A5, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h1234, 1'b0, 1'b0, 10'd2, 16'hA5A5, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 10'd2, 16'hA5A5, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 10'd2, 16'hA5A5, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 10'd2, 16'hA5A5, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h0F0F, 1'b1, 1'b0, 10'd3, 16'hA5A5, 1'b0, 1'b0};

        bus.i_valid = 1'b0;
        bus.i_data = 16'h0;
        bus.i_rd = 1'b0;
        bus.i_burst_ack = 1'b0;
        rst_n = 1'b0;
        step();
        chk("rst_req", 32'(bus.o_burst_req), 32'd0);
        chk("rst_addr", 32'(bus.o_burst_addr), 32'd0);
        chk("rst_len", 32'(bus.o_burst_len), 32'd0);
        chk("rst_level", 32'(bus.o_level), 32'd0);
        chk("rst_ovf", 32'(bus.o_overflow), 32'd0);
        chk("rst_fdone", 32'(bus.o_frame_done), 32'd0);
        chk("rst_rdata", 32'(bus.o_rd_data), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            bus.i_valid     = vecs[i].valid;
            bus.i_data      = vecs[i].data;
            bus.i_rd        = vecs[i].rd;
            bus.i_burst_ack = vecs[i].ack;
            step();
            chk("vec_level", 32'(bus.o_level), 32'(vecs[i].lvl));
            chk("vec_rdata", 32'(bus.o_rd_data), 32'(vecs[i].rdd));
            chk("vec_req", 32'(bus.o_burst_req), 32'(vecs[i].req));
            chk("vec_ovf", 32'(bus.o_overflow), 32'(vecs[i].ovf));
        end

        // First burst: request appears the cycle after level reaches 256
        do_reset();
        push_n(256, 16'h0000);
        chk("b1_level", 32'(bus.o_level), 32'd256);
        chk("b1_req_early", 32'(bus.o_burst_req), 32'd0);
        step();
        chk("b1_req", 32'(bus.o_burst_req), 32'd1);
        chk("b1_addr", 32'(bus.o_burst_addr), 32'd0);
        chk("b1_len", 32'(bus.o_burst_len), 32'd256);
        bus.i_burst_ack = 1'b1;
        step();
        bus.i_burst_ack = 1'b0;
        chk("b1_req_drop", 32'(bus.o_burst_req), 32'd0);
        for (int i = 0; i < 256; i++) begin
            chk("b1_data", 32'(bus.o_rd_data), 32'(i));
            bus.i_rd = 1'b1;
            step();
        end
        bus.i_rd = 1'b0;
        chk("b1_level_end", 32'(bus.o_level), 32'd0);
        step();
        chk("b1_idle", 32'(bus.o_burst_req), 32'd0);

        push_n(256, 16'h0100);
        serve_burst(23'd256, 256, 16'h0100, fd);
        chk("b2_fdone", 32'(fd), 32'd0);

        // Frame end at word 1000: flush burst of 232 at 768, then wrap to 0
        push_n(488, 16'h0200);
        chk("fr_ovf", 32'(bus.o_overflow), 32'd0);
        serve_burst(23'd512, 256, 16'h0200, fd);
        chk("fr_fdone_mid", 32'(fd), 32'd0);
        serve_burst(23'd768, 232, 16'h0300, fd);
        chk("fr_fdone", 32'(fd), 32'd1);
        step();
        chk("fr_fdone_pulse", 32'(bus.o_frame_done), 32'd0);
        chk("fr_level", 32'(bus.o_level), 32'd0);
        push_n(256, 16'h0400);
        serve_burst(23'd0, 256, 16'h0400, fd);

        // Reset in the middle of a transfer
        push_n(256, 16'h0600);
        wait_req(10, seen);
        bus.i_burst_ack = 1'b1;
        step();
        bus.i_burst_ack = 1'b0;
        bus.i_rd = 1'b1;
        repeat (10) step();
        bus.i_rd = 1'b0;
        chk("mr_level_pre", 32'(bus.o_level), 32'd246);
        rst_n = 1'b0;
        #1;
        chk("mr_req", 32'(bus.o_burst_req), 32'd0);
        chk("mr_level", 32'(bus.o_level), 32'd0);
        chk("mr_addr", 32'(bus.o_burst_addr), 32'd0);
        chk("mr_len", 32'(bus.o_burst_len), 32'd0);
        chk("mr_rdata", 32'(bus.o_rd_data), 32'd0);
        step();
        rst_n = 1'b1;
        push_n(1, 16'hBEEF);
        chk("mr_push_level", 32'(bus.o_level), 32'd1);
        chk("mr_push_data", 32'(bus.o_rd_data), 32'hBEEF);

        // Overflow: 520 pushes into 512 slots, dropped words still counted
        do_reset();
        push_n(520, 16'h1000);
        chk("of_level", 32'(bus.o_level), 32'd512);
        chk("of_ovf", 32'(bus.o_overflow), 32'd1);
        serve_burst(23'd0, 256, 16'h1000, fd);
        serve_burst(23'd256, 256, 16'h1100, fd);
        chk("of_drained", 32'(bus.o_level), 32'd0);
        chk("of_sticky", 32'(bus.o_overflow), 32'd1);
        push_n(480, 16'h2000);
        serve_burst(23'd512, 256, 16'h2000, fd);
        serve_burst(23'd768, 224, 16'h2100, fd);
        chk("of_fdone", 32'(fd), 32'd0);

        // Simultaneous push and pop while full
        do_reset();
        push_n(512, 16'h3000);
        chk("fp_req", 32'(bus.o_burst_req), 32'd1);
        bus.i_burst_ack = 1'b1;
        step();
        bus.i_burst_ack = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 16'h5555;
        bus.i_rd    = 1'b1;
        step();
        bus.i_rd    = 1'b0;
        chk("fp_level", 32'(bus.o_level), 32'd512);
        chk("fp_ovf", 32'(bus.o_overflow), 32'd0);
        chk("fp_head", 32'(bus.o_rd_data), 32'h3001);
        step();
        bus.i_valid = 1'b0;
        chk("fp_full_drop_ovf", 32'(bus.o_overflow), 32'd1);
        chk("fp_full_drop_level", 32'(bus.o_level), 32'd512);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/comp_wr_buffer.md
Name: comp_wr_buffer

Overview:
- Sits directly downstream of the DPCM compressor, between it and the SDRAM write port.
- Accepts 16-bit compressed pixel words at camera pixel rate, buffers them in a FIFO, and issues fixed-length burst write requests with linear frame addresses.
- Covers 800x600 frames (480000 words), so the SDRAM controller sees bursts instead of a per-pixel stream.

Parameters:
- DEPTH, 512: FIFO depth in 16-bit words; power of 2, >= 2*BURST.
- BURST, 256: maximum burst length in words; <= 255 is not required, length port is 9 bits.
- FRAME_PIX, 480000: words per frame (800*600).
- BASE_ADDR, 0: SDRAM word address of word 0 of the frame.
- ADDR_W, 23: SDRAM word-address width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  compressed word strobe from compressor
- i_data  in  16  compressed word (R5 G6 B5 difference codes)
- o_burst_req  out  1  burst write request
- o_burst_addr  out  ADDR_W  start word address of the requested burst
- o_burst_len  out  9  words in the requested burst, 1..BURST
- i_burst_ack  in  1  controller accepts the request (1-cycle pulse)
- i_rd  in  1  controller pops one word during a burst
- o_rd_data  out  16  FIFO head word (show-ahead)
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- o_overflow  out  1  sticky: a word was dropped
- o_frame_done  out  1  1-cycle pulse when the last word of a frame has been popped

Behaviour:
- Reset: all outputs 0, FIFO empty, pointers 0, offset 0, FSM IDLE. Reset is honoured mid-burst; no partial state survives it.
- FIFO push:
  - Occurs on i_valid when level < DEPTH, or when level == DEPTH and a pop happens in the same cycle.
  - Otherwise the word is dropped and o_overflow is set; it is cleared only by reset.
- FIFO pop:
  - Occurs on i_rd only in XFER and only when level > 0.
  - i_rd in any other state, or while empty, is ignored; the controller is responsible for it not happening.
- Simultaneous push and pop: level unchanged.
- o_rd_data always shows the head word; its value is don't-care when empty. Data is visible the cycle after push: write-to-read latency is 1 cycle.
- Input counter in_cnt (0..FRAME_PIX-1):
  - Increments on every i_valid, including dropped words, so frame alignment is kept.
  - Wraps to 0 after FRAME_PIX-1.
  - On the wrap, flush_pend is set.
- FSM:
  - IDLE → REQ when level >= BURST, or when flush_pend and level > 0.
    - On entry, latch len = min(level, BURST) and addr = BASE_ADDR + offset.
    - If flush_pend and level == 0, clear flush_pend and stay in IDLE.
  - REQ: hold o_burst_req=1 with addr and len stable until i_burst_ack, then go to XFER and drop o_burst_req the next cycle.
  - XFER: count pops. When the count reaches len, return to IDLE, advance offset by len, and clear flush_pend if level is now 0.
- Offset wrap:
  - When offset+len == FRAME_PIX, offset wraps to 0 and o_frame_done pulses for 1 cycle.
  - A burst never spans the frame boundary: len = min(level, BURST, FRAME_PIX-offset).
- o_burst_addr and o_burst_len hold their last values outside REQ.
- Arithmetic: offset is 19 bits; addr = BASE_ADDR + offset, truncated to ADDR_W.
- Throughput: one push and one pop per cycle are sustainable; the FSM adds 1 idle cycle between bursts.

Test Plan:
- Reset, then 256 consecutive i_valid with data 0x0000..0x00FF → o_burst_req rises the cycle after level hits 256, with addr=0 and len=256. Ack, then 256 pops → o_rd_data 0x0000..0x00FF in order, level 0, FSM IDLE.
- Stream two bursts, popping each → second request has addr=256, len=256.
- Hold i_rd low and push 520 words → level saturates at 512, o_overflow=1, words 513..520 are lost. After draining, in_cnt still reflects 520.
- Push and pop in the same cycle at level 512 → push accepted, level stays 512, o_overflow stays 0.
- Full frame of 480000 words with immediate ack/pop → 1875 bursts; the last has addr=479744, len=256. o_frame_done pulses once, then the next request has addr=0.
- Set FRAME_PIX=1000 and push 1000 words → final burst len=232 (flush), addr=768. Then assert reset during XFER → outputs 0 and the FIFO is empty the next cycle.
